// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multicycle MIPS main control.
// Holds the state enum, opcode constants, mux/ALU encodings and the control bundle.
package mc_ctrl_pkg;

    localparam int OPCODE_W = 6;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_RT     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// mc_ctrl_out_decode: combinational map from FSM state to datapath controls.
// Ports: state, mem_ready (only matters in FETCH) -> ctrl bundle.
module mc_ctrl_out_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b0;
                // IR and PC+4 only load on the cycle the fetch completes
                if (mem_ready) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.alu_src_a = 1'b0;
                    ctrl.alu_src_b = ALUSRCB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.pc_src    = PCSRC_ALU;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALUSRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_RT;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.branch    = 1'b1;
                ctrl.pc_src    = PCSRC_ALUOUT;
            end
`ifdef MULTICYCLE_CTRL_JUMP_EN
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: main control FSM of the multicycle MIPS datapath.
// Ports: clk, rst_n, opcode, mem_ready in; mem/PC/IR/ALU/regfile controls,
// illegal_op out. Macro MULTICYCLE_CTRL_JUMP_EN enables the j (000010) path.
module multicycle_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                iord,
    output logic                mem_write,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                illegal_op
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   illegal;

    logic is_mem;
    logic is_r;
    logic is_beq;
    logic is_j;

    assign is_mem = (opcode == OP_LW) || (opcode == OP_SW);
    assign is_r   = (opcode == OP_RTYPE);
    assign is_beq = (opcode == OP_BEQ);
`ifdef MULTICYCLE_CTRL_JUMP_EN
    assign is_j   = (opcode == OP_J);
`else
    assign is_j   = 1'b0;
`endif

    always_comb begin
        state_nxt = S_FETCH;
        illegal   = 1'b0;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (1'b1)
                    is_mem: state_nxt = S_MEM_ADDR;
                    is_r:   state_nxt = S_EXECUTE;
                    is_beq: state_nxt = S_BRANCH;
                    is_j:   state_nxt = S_JUMP;
                    default: begin
                        illegal   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW)
                    state_nxt = S_MEM_READ;
                else if (opcode == OP_SW)
                    state_nxt = S_MEM_WRITE;
                else
                    state_nxt = S_FETCH;
            end
            S_MEM_READ:  state_nxt = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_nxt = S_FETCH;
            S_MEM_WRITE: state_nxt = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_nxt = S_ALU_WB;
            S_ALU_WB:    state_nxt = S_FETCH;
            S_BRANCH:    state_nxt = S_FETCH;
            S_JUMP:      state_nxt = S_FETCH;
            default:     state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    mc_ctrl_out_decode u_out_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign mem_req    = ctrl.mem_req;
    assign iord       = ctrl.iord;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign branch     = ctrl.branch;
    assign pc_src     = ctrl.pc_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign illegal_op = illegal;

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: random instruction stream vs. a phase-list model.
// Each instruction expands into its spec phase sequence; outputs checked per cycle.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req, iord, mem_write, ir_write, pc_write, branch;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op;
    logic [16:0] got;

    int n_chk  = 0;
    int n_fail = 0;

    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_MADDR  = 2;
    localparam int PH_MREAD  = 3;
    localparam int PH_MWB    = 4;
    localparam int PH_MWRITE = 5;
    localparam int PH_EXEC   = 6;
    localparam int PH_ALUWB  = 7;
    localparam int PH_BRANCH = 8;
    localparam int PH_JUMP   = 9;

    multicycle_main_control #(.OPCODE_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .branch     (branch),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal_op (illegal_op)
    );

    assign got = {mem_req, iord, mem_write, ir_write, pc_write, branch,
                  pc_src, alu_src_a, alu_src_b, alu_op,
                  reg_dst, mem_to_reg, reg_write, illegal_op};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
        end
    endtask

    // Expected control vector for one cycle of a given phase
    function automatic logic [16:0] exp_vec(int ph, bit rdy, bit ill);
        logic       mreq = 0, io = 0, mw = 0, irw = 0, pcw = 0, br = 0;
        logic [1:0] pcs = 0, asb = 0, aop = 0;
        logic       asa = 0, rdst = 0, m2r = 0, rw = 0, il = 0;
        case (ph)
            PH_FETCH:  begin
                mreq = 1;
                if (rdy) begin irw = 1; pcw = 1; asb = 2'b01; end
            end
            PH_DECODE: begin asb = 2'b11; il = ill; end
            PH_MADDR:  begin asa = 1; asb = 2'b10; end
            PH_MREAD:  begin mreq = 1; io = 1; end
            PH_MWB:    begin rw = 1; m2r = 1; end
            PH_MWRITE: begin mreq = 1; io = 1; mw = 1; end
            PH_EXEC:   begin asa = 1; aop = 2'b10; end
            PH_ALUWB:  begin rw = 1; rdst = 1; end
            PH_BRANCH: begin asa = 1; aop = 2'b01; br = 1; pcs = 2'b01; end
            PH_JUMP:   begin pcw = 1; pcs = 2'b10; end
            default:   ;
        endcase
        return {mreq, io, mw, irw, pcw, br, pcs, asa, asb, aop,
                rdst, m2r, rw, il};
    endfunction

    task automatic cyc(input int ph, input bit rdy, input bit ill,
                       input logic [5:0] op, input string tag);
        mem_ready = rdy;
        opcode    = op;
        @(negedge clk);
        chk(tag, {15'd0, got}, {15'd0, exp_vec(ph, rdy, ill)});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] junk();
        return 6'($urandom);
    endfunction

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input int idx, input logic [5:0] op,
                             input int fw, input int mw);
        bit is_lw, is_sw, is_r, is_beq, is_j;
        string t;
        is_lw  = (op == 6'b100011);
        is_sw  = (op == 6'b101011);
        is_r   = (op == 6'b000000);
        is_beq = (op == 6'b000100);
`ifdef MULTICYCLE_CTRL_JUMP_EN
        is_j   = (op == 6'b000010);
`else
        is_j   = 0;
`endif
        for (int w = 0; w <= fw; w++) begin
            t = $sformatf("i%0d_op%02h_fetch%0d", idx, op, w);
            cyc(PH_FETCH, w == fw, 0, junk(), t);
        end
        t = $sformatf("i%0d_op%02h_decode", idx, op);
        cyc(PH_DECODE, rbit(), !(is_lw | is_sw | is_r | is_beq | is_j), op, t);
        if (is_lw || is_sw) begin
            t = $sformatf("i%0d_op%02h_maddr", idx, op);
            cyc(PH_MADDR, rbit(), 0, op, t);
            for (int w = 0; w <= mw; w++) begin
                t = $sformatf("i%0d_op%02h_mem%0d", idx, op, w);
                cyc(is_lw ? PH_MREAD : PH_MWRITE, w == mw, 0, junk(), t);
            end
            if (is_lw) begin
                t = $sformatf("i%0d_op%02h_memwb", idx, op);
                cyc(PH_MWB, rbit(), 0, junk(), t);
            end
        end else if (is_r) begin
            t = $sformatf("i%0d_op%02h_exec", idx, op);
            cyc(PH_EXEC, rbit(), 0, junk(), t);
            t = $sformatf("i%0d_op%02h_aluwb", idx, op);
            cyc(PH_ALUWB, rbit(), 0, junk(), t);
        end else if (is_beq) begin
            t = $sformatf("i%0d_op%02h_branch", idx, op);
            cyc(PH_BRANCH, rbit(), 0, junk(), t);
        end else if (is_j) begin
            t = $sformatf("i%0d_op%02h_jump", idx, op);
            cyc(PH_JUMP, rbit(), 0, junk(), t);
        end
    endtask

    task automatic reset_release(input string tag);
        mem_ready = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        chk({tag, "_idle"}, {15'd0, got}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [5:0] ops [5];
    logic [5:0] op;
    int         k;

    initial begin
        ops[0] = 6'b100011;
        ops[1] = 6'b101011;
        ops[2] = 6'b000000;
        ops[3] = 6'b000100;
        ops[4] = 6'b000010;

        rst_n     = 0;
        mem_ready = 1;
        opcode    = 6'b100011;
        #12;
        chk("reset_all_zero", {15'd0, got}, 32'd0);
        reset_release("por");

        run_instr(0, 6'b100011, 0, 0);
        run_instr(1, 6'b000000, 0, 0);
        run_instr(2, 6'b000100, 0, 0);
        run_instr(3, 6'b101011, 0, 3);
        run_instr(4, 6'b000010, 0, 0);
        run_instr(5, 6'b111111, 1, 0);
        run_instr(6, 6'b100011, 2, 2);

        // reset dropped while a store waits on memory
        run_instr(7, 6'b000000, 0, 0);
        cyc(PH_FETCH, 1, 0, junk(), "rst_fetch");
        cyc(PH_DECODE, 0, 0, 6'b101011, "rst_decode");
        cyc(PH_MADDR, 0, 0, 6'b101011, "rst_maddr");
        cyc(PH_MWRITE, 0, 0, junk(), "rst_mw0");
        mem_ready = 0;
        #1;
        chk("rst_pre_mem_write", {31'd0, mem_write}, 32'd1);
        rst_n = 0;
        #1;
        chk("rst_mid_zero", {15'd0, got}, 32'd0);
        reset_release("mid");

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 5);
            if (k < 5) begin
                op = ops[k];
            end else begin
                op = 6'b100011;
                while (op == 6'b100011 || op == 6'b101011 ||
                       op == 6'b000000 || op == 6'b000100 ||
                       op == 6'b000010)
                    op = junk();
            end
            run_instr(100 + i, op, $urandom_range(0, 2), $urandom_range(0, 3));
        end
        cyc(PH_FETCH, 0, 0, junk(), "final_fetch");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
